// File: rtl/hbm_pkg.sv
// hbm_pkg: shared types and constants for the HBM read arbiter.
//   ar_req_t     - one registered AR request (id is zero-extended to HBM_ID_W)
//   slot_state_e - occupancy of the single AR output register
package hbm_pkg;
  localparam int HBM_ID_W = 8;
  localparam int AR_ADDR_W = 64;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef struct packed {
    logic [HBM_ID_W-1:0] id;
    logic [AR_ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_req_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered priority pointer.
//   clk, rst        - clock, asynchronous active-high reset (pointer -> 0)
//   req_i           - request vector
//   advance_i       - a grant was taken this cycle; pointer moves past grant_idx_i
//   grant_idx_i     - index of the grant that was taken
//   grant_onehot_o  - one-hot grant (zero when no request)
//   grant_idx_o     - binary index of the grant
//   any_grant_o     - at least one request present
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  input  logic [W-1:0] grant_idx_i,
  output logic [N-1:0] grant_onehot_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_grant_o
);
  logic [W-1:0] ptr_q, ptr_d;
  function automatic logic [W-1:0] wrap(input int v);
    return W'(v >= N ? v - N : v);
  endfunction
  // Scan from the farthest offset down so the nearest request to the pointer wins.
  always_comb begin
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap(int'(ptr_q) + k)]) begin
        grant_idx_o = wrap(int'(ptr_q) + k);
        any_grant_o = 1'b1;
      end
    end
    grant_onehot_o = any_grant_o ? N'(1) << grant_idx_o : '0;
    ptr_d = advance_i ? (grant_idx_i == W'(N - 1) ? '0 : grant_idx_i + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/hbm_read_arbiter.sv
// hbm_read_arbiter: N-master to 1-channel AXI4 read arbiter in front of one HBM channel.
//   clk, rst                       - clock, asynchronous active-high reset
//   m_ar*_i / m_arready_o          - flattened per-master AR channels, master 0 in the LSBs
//   m_r*_o / m_rvalid_o / m_rready_i - broadcast R payload, per-master valid/ready
//   hbm_ar*_o / hbm_arready_i      - registered AR towards HBM, id = {master idx, master id}
//   hbm_r*_i / hbm_rready_o        - R from HBM, routed by the master idx in hbm_rid_i
//   outstanding_o                  - per-master in-flight burst counts, 8 bits each
//   err_unmapped_o                 - sticky: an R beat carried a master idx >= NUM_MASTERS
module hbm_read_arbiter
  import hbm_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int MID_W = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*MID_W-1:0]  m_arid_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr_i,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen_i,
  input  logic [NUM_MASTERS*3-1:0]      m_arsize_i,
  input  logic [NUM_MASTERS*2-1:0]      m_arburst_i,
  input  logic [NUM_MASTERS-1:0]        m_arvalid_i,
  output logic [NUM_MASTERS-1:0]        m_arready_o,
  output logic [MID_W-1:0]              m_rid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [1:0]                    m_rresp_o,
  output logic                          m_rlast_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]        m_rready_i,
  output logic [IDX_W+MID_W-1:0]        hbm_arid_o,
  output logic [ADDR_W-1:0]             hbm_araddr_o,
  output logic [7:0]                    hbm_arlen_o,
  output logic [2:0]                    hbm_arsize_o,
  output logic [1:0]                    hbm_arburst_o,
  output logic                          hbm_arvalid_o,
  input  logic                          hbm_arready_i,
  input  logic [IDX_W+MID_W-1:0]        hbm_rid_i,
  input  logic [DATA_W-1:0]             hbm_rdata_i,
  input  logic [1:0]                    hbm_rresp_i,
  input  logic                          hbm_rlast_i,
  input  logic                          hbm_rvalid_i,
  output logic                          hbm_rready_o,
  output logic [NUM_MASTERS*8-1:0]      outstanding_o,
  output logic                          err_unmapped_o
);
  slot_state_e state_q, state_d;
  ar_req_t slot_q, slot_d;
  logic [NUM_MASTERS-1:0] elig, gnt_oh;
  logic [IDX_W-1:0] gnt_idx, r_idx;
  logic any_gnt, load_en, accept, mapped, r_done, err_q, err_d;
  logic [7:0] cnt_q [NUM_MASTERS];
  logic [7:0] cnt_d [NUM_MASTERS];
  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .clk(clk),
    .rst(rst),
    .req_i(elig),
    .advance_i(accept),
    .grant_idx_i(gnt_idx),
    .grant_onehot_o(gnt_oh),
    .grant_idx_o(gnt_idx),
    .any_grant_o(any_gnt)
  );
  // The slot reloads whenever it is empty or its content leaves this cycle.
  // Gating with rst keeps every ready low while reset is held.
  assign load_en = (state_q == SLOT_EMPTY) | (hbm_arvalid_o & hbm_arready_i);
  assign accept = load_en & any_gnt & ~rst;
  assign m_arready_o = accept ? gnt_oh : '0;
  always_comb begin
    state_d = load_en ? (accept ? SLOT_FULL : SLOT_EMPTY) : state_q;
    slot_d = slot_q;
    if (accept) begin
      slot_d.id = HBM_ID_W'({gnt_idx, m_arid_i[gnt_idx*MID_W +: MID_W]});
      slot_d.addr = AR_ADDR_W'(m_araddr_i[gnt_idx*ADDR_W +: ADDR_W]);
      slot_d.len = m_arlen_i[gnt_idx*8 +: 8];
      slot_d.size = m_arsize_i[gnt_idx*3 +: 3];
      slot_d.burst = m_arburst_i[gnt_idx*2 +: 2];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SLOT_EMPTY;
      slot_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
    end
  assign hbm_arvalid_o = state_q == SLOT_FULL;
  assign hbm_arid_o = slot_q.id[IDX_W+MID_W-1:0];
  assign hbm_araddr_o = slot_q.addr[ADDR_W-1:0];
  assign hbm_arlen_o = slot_q.len;
  assign hbm_arsize_o = slot_q.size;
  assign hbm_arburst_o = slot_q.burst;
  // R demux: beats for a non-existent master are drained so HBM never stalls.
  assign r_idx = hbm_rid_i[IDX_W+MID_W-1:MID_W];
  assign mapped = int'(r_idx) < NUM_MASTERS;
  always_comb begin
    hbm_rready_o = ~mapped;
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        hbm_rready_o = m_rready_i[i];
        m_rvalid_o[i] = hbm_rvalid_i & ~rst;
      end
    end
  end
  assign r_done = hbm_rvalid_i & hbm_rready_o & hbm_rlast_i & mapped;
  assign m_rid_o = hbm_rid_i[MID_W-1:0];
  assign m_rdata_o = hbm_rdata_i;
  assign m_rresp_o = hbm_rresp_i;
  assign m_rlast_o = hbm_rlast_i;
  // Eligibility stops increments at the limit, so counters cannot wrap upward.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_cnt
    logic inc, dec;
    assign elig[i] = m_arvalid_i[i] & (cnt_q[i] < 8'(MAX_OUTSTANDING));
    assign inc = m_arready_o[i];
    assign dec = r_done & (r_idx == IDX_W'(i));
    assign cnt_d[i] = inc == dec ? cnt_q[i] : inc ? cnt_q[i] + 8'd1 : cnt_q[i] - 8'd1;
    assign outstanding_o[i*8 +: 8] = cnt_q[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  assign err_d = err_q | (hbm_rvalid_i & ~mapped);
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_unmapped_o = err_q;
endmodule
